addr_gen_1: RTL and testbench
=============================

Name: addr_gen_1

Overview:
- Address and RAM-control generator for an in-place constant-geometry NTT over four true-dual-port coefficient banks (ram0..ram3), each 2^ADDR_W words deep.
- ram0/ram1 form ping pair P0 (lower/upper half of the coefficient vector); ram2/ram3 form pong pair P1.
- Each stage reads one pair and writes the other. It drives read/write addresses, per-port enables and write strobes, and a BFU enable.
- Sits between the top-level controller (start/valid) and the butterfly unit/RAM array.

Parameters:
- ADDR_W, 7, bank address width. M = 2^ADDR_W butterflies per stage; N = 2M points.
- PIPE_LAT, 5, cycles from read issue to write of the same butterfly (1 RAM read + BFU latency); valid range 2..15.
- NUM_STAGES, ADDR_W+1, derived and not overridable; number of NTT stages (≤31).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset), despite the legacy name.
- start  in  1  pulse; arms a new transform from IDLE or DONE.
- valid  in  1  issue enable; butterflies issue only in cycles where valid=1.
- i  out  ADDR_W+1  butterfly index within the current stage.
- stage  out  5  current stage 0..NUM_STAGES-1; equals NUM_STAGES when finished.
- bfu_en  out  1  operands present at BFU input this cycle.
- ram0_ena..ram3_ena, ram0_enb..ram3_enb  out  1 each  port enables.
- ram0_wea..ram3_wea, ram0_web..ram3_web  out  1 each  port write strobes.
- w_ram_flag  out  1  destination half of the write pair (0 = lower bank, 1 = upper bank).
- stage_flag  out  1  stage[0]; 0 = read P0/write P1, 1 = read P1/write P0.
- w_addr_0, w_addr_1, r_addr_0, r_addr_1  out  ADDR_W each  write port a/b and read addresses.

Behaviour:
- Reset: state IDLE; i=0, stage=0; every enable, strobe, flag, bfu_en and address is 0; delay pipeline cleared. Reset mid-operation aborts immediately with no further writes.
- FSM states:
  - IDLE: on start go to RUN.
  - RUN: in each cycle with valid=1, issue butterfly i and increment i. On issuing i=M-1, go to DRAIN. Cycles with valid=0 issue nothing and hold i.
  - DRAIN: count PIPE_LAT cycles, then set i=0 and stage+1. If the new stage is NUM_STAGES, go to DONE; otherwise go to RUN.
  - DONE: hold stage=NUM_STAGES; start restarts at stage 0 (goes to RUN).
- Read issue (combinational, same cycle):
  - r_addr_0 = r_addr_1 = i[ADDR_W-1:0].
  - Read port-a enables of both read-pair banks are 1; wea=0.
  - Read-pair enb signals are 0.
- Writes: the issue event, stage_flag and write addresses travel down a PIPE_LAT-deep register pipeline. At the output:
  - w_addr_0 = (2i) mod M, w_addr_1 = (2i+1) mod M.
  - w_ram_flag = i[ADDR_W-1].
  - The selected write-pair bank asserts ena, enb, wea and web together; the other write-pair bank is idle.
- bfu_en = issue event delayed 1 cycle.
- Writes of a stage always complete before the next stage's first read; no read/write bank overlap.
- start is ignored while in RUN or DRAIN.
- All write-side outputs are 0 whenever no delayed issue is present.
- Addresses are don't-care but held stable when the corresponding enable is low.

Optional Feature:
- ADDR_GEN_DONE_PULSE_EN defined: adds output done (1 bit). It pulses high for exactly one cycle on the DRAIN→DONE transition and is reset to 0.
- Undefined: no done port; completion is signalled only by stage==NUM_STAGES.

Decomposition:
- Shared package holds the ADDR_W default (the codebase address-width constant), the PIPE_LAT default, the FSM state enum (IDLE/RUN/DRAIN/DONE) and the bank-index constants.
- One sub-module: addr_gen_delay_line, a parameterised PIPE_LAT-deep shift register carrying {issue, stage_flag, w_ram_flag, w_addr_0, w_addr_1}.

Test Plan (ADDR_W=3, PIPE_LAT=3, M=8, 4 stages):
- Reset held, then released; start with valid low -> FSM in RUN, all enables 0, i=0, stage=0.
- valid=1 continuously, stage 0 -> r_addr=i and ram0_ena=ram1_ena=1 for 8 cycles. 3 cycles after issuing i=5: w_addr_0=2, w_addr_1=3, w_ram_flag=1, and ram3_ena/enb/wea/web=1.
- Toggle valid every other cycle -> i advances only on valid cycles; exactly 8 writes per stage with bubbles preserved.
- Stage 1 -> stage_flag=1, reads from ram2/ram3, writes to ram0 (i<4) or ram1 (i≥4); i=0 resumes only 3 cycles after last issue.
- Run to completion -> stage=4 in DONE with no enables; a new start restarts at stage 0 (with done macro: single-cycle done pulse).
- Assert reset during stage 2 DRAIN -> next cycle all outputs 0 and no pending write emerges.

Source files
------------

// File: rtl/addr_gen_1_pkg.sv
// Shared constants and types for the NTT address generator.
// Pure declarations, no logic, no latency.
// No flow control of its own.
package addr_gen_1_pkg;

  // Default coefficient-bank address width used across the codebase
  localparam int ADDR_W_DEF   = 7;
  // Default read-issue to write latency (RAM read + butterfly pipeline)
  localparam int PIPE_LAT_DEF = 5;

  // Stage counter width; NUM_STAGES never exceeds 31
  localparam int STAGE_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bank indices: ram0/ram1 = ping pair P0, ram2/ram3 = pong pair P1
  localparam int BANK_RAM0 = 0;
  localparam int BANK_RAM1 = 1;
  localparam int BANK_RAM2 = 2;
  localparam int BANK_RAM3 = 3;

endpackage

// File: rtl/addr_gen_delay_line.sv
// Fixed-depth shift register carrying the write-side context of each issue slot.
// Latency: exactly DEPTH cycles from i_dat to o_dat.
// No backpressure: shifts every cycle, bubbles travel as issue=0 entries.
module addr_gen_delay_line
  import addr_gen_1_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  // Shift one slot per cycle; reset flushes any pending writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[DEPTH-2:0], i_dat};
    end
  end

  assign o_dat = r_pipe[DEPTH-1];

endmodule

// File: rtl/addr_gen_1.sv
// Address/RAM-control generator for an in-place constant-geometry NTT over 4 banks.
// Reads issue combinationally; writes emerge PIPE_LAT cycles later, bfu_en 1 cycle later.
// Issues only when valid=1; optional done pulse under ADDR_GEN_DONE_PULSE_EN.
module addr_gen_1
  import addr_gen_1_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              valid,
`ifdef ADDR_GEN_DONE_PULSE_EN
  output logic              done,
`endif
  output logic [ADDR_W:0]   i,
  output logic [4:0]        stage,
  output logic              bfu_en,
  output logic              ram0_ena,
  output logic              ram1_ena,
  output logic              ram2_ena,
  output logic              ram3_ena,
  output logic              ram0_enb,
  output logic              ram1_enb,
  output logic              ram2_enb,
  output logic              ram3_enb,
  output logic              ram0_wea,
  output logic              ram1_wea,
  output logic              ram2_wea,
  output logic              ram3_wea,
  output logic              ram0_web,
  output logic              ram1_web,
  output logic              ram2_web,
  output logic              ram3_web,
  output logic              w_ram_flag,
  output logic              stage_flag,
  output logic [ADDR_W-1:0] w_addr_0,
  output logic [ADDR_W-1:0] w_addr_1,
  output logic [ADDR_W-1:0] r_addr_0,
  output logic [ADDR_W-1:0] r_addr_1
);

  localparam int NUM_STAGES = ADDR_W + 1;
  localparam int DL_W       = 3 + 2 * ADDR_W;

  localparam logic [ADDR_W:0]  LAST_I     = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]  I_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]       LAST_CNT   = 4'(PIPE_LAT - 1);
  localparam logic [4:0]       LAST_STAGE = 5'(NUM_STAGES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_i;
  logic [4:0]        r_stage;
  logic [3:0]        r_cnt;
  logic              r_bfu_en;
  logic [ADDR_W-1:0] r_wa0_hold;
  logic [ADDR_W-1:0] r_wa1_hold;

  logic              w_issue;
  logic              w_drain_end;
  logic              w_last_stage;
  logic [3:0]        w_rd_en;
  logic [3:0]        w_wr_en;

  logic [DL_W-1:0]   w_dl_in;
  logic [DL_W-1:0]   w_dl_out;
  logic              w_d_issue;
  logic              w_d_sflag;
  logic              w_d_wflag;
  logic [ADDR_W-1:0] w_d_wa0;
  logic [ADDR_W-1:0] w_d_wa1;

  assign w_issue      = (r_state == ST_RUN) & valid;
  assign w_drain_end  = (r_state == ST_DRAIN) & (r_cnt == LAST_CNT);
  assign w_last_stage = (r_stage == LAST_STAGE);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured from IDLE or DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue && (r_i == LAST_I)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = w_last_stage ? ST_DONE : ST_RUN;
      ST_DONE:  if (start) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Butterfly index and stage counters
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_i     <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_issue) r_i <= r_i + I_ONE;
        end
        ST_DRAIN: begin
          if (w_drain_end) begin
            r_i     <= '0;
            r_stage <= r_stage + 5'd1;
          end
        end
        default: begin
          if (start) begin
            r_i     <= '0;
            r_stage <= '0;
          end
        end
      endcase
    end
  end

  // Drain counter: waits for the last write of the stage to leave the pipeline
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == ST_DRAIN) && !w_drain_end) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Write context: stage_flag, destination half and the butterfly's two output addresses
  assign w_dl_in = {w_issue, r_stage[0], r_i[ADDR_W-1],
                    r_i[ADDR_W-2:0], 1'b0,
                    r_i[ADDR_W-2:0], 1'b1};

  addr_gen_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (DL_W)
  ) u_delay_line (
    .i_clk (clk),
    .i_rst (rst_n),
    .i_dat (w_dl_in),
    .o_dat (w_dl_out)
  );

  assign {w_d_issue, w_d_sflag, w_d_wflag, w_d_wa0, w_d_wa1} = w_dl_out;

  // BFU sees operands one cycle after the read; hold last write addresses while idle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_bfu_en   <= 1'b0;
      r_wa0_hold <= '0;
      r_wa1_hold <= '0;
    end else begin
      r_bfu_en <= w_issue;
      if (w_d_issue) begin
        r_wa0_hold <= w_d_wa0;
        r_wa1_hold <= w_d_wa1;
      end
    end
  end

  // Bank enables: read pair from current stage_flag, write bank from delayed context
  always_comb begin
    w_rd_en = '0;
    w_wr_en = '0;
    if (w_issue) begin
      if (r_stage[0]) begin
        w_rd_en[BANK_RAM2] = 1'b1;
        w_rd_en[BANK_RAM3] = 1'b1;
      end else begin
        w_rd_en[BANK_RAM0] = 1'b1;
        w_rd_en[BANK_RAM1] = 1'b1;
      end
    end
    if (w_d_issue) begin
      if (w_d_sflag) begin
        if (w_d_wflag) w_wr_en[BANK_RAM1] = 1'b1;
        else           w_wr_en[BANK_RAM0] = 1'b1;
      end else begin
        if (w_d_wflag) w_wr_en[BANK_RAM3] = 1'b1;
        else           w_wr_en[BANK_RAM2] = 1'b1;
      end
    end
  end

`ifdef ADDR_GEN_DONE_PULSE_EN
  logic r_done;

  // One-cycle pulse coinciding with the first DONE cycle
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_drain_end & w_last_stage;
    end
  end

  assign done = r_done;
`endif

  assign i          = r_i;
  assign stage      = r_stage;
  assign stage_flag = r_stage[0];
  assign bfu_en     = r_bfu_en;

  assign r_addr_0   = r_i[ADDR_W-1:0];
  assign r_addr_1   = r_i[ADDR_W-1:0];

  assign w_ram_flag = w_d_issue & w_d_wflag;
  assign w_addr_0   = w_d_issue ? w_d_wa0 : r_wa0_hold;
  assign w_addr_1   = w_d_issue ? w_d_wa1 : r_wa1_hold;

  // Read and write never target the same bank in a cycle, so port a is shared by OR
  assign ram0_ena = w_rd_en[BANK_RAM0] | w_wr_en[BANK_RAM0];
  assign ram1_ena = w_rd_en[BANK_RAM1] | w_wr_en[BANK_RAM1];
  assign ram2_ena = w_rd_en[BANK_RAM2] | w_wr_en[BANK_RAM2];
  assign ram3_ena = w_rd_en[BANK_RAM3] | w_wr_en[BANK_RAM3];

  assign ram0_enb = w_wr_en[BANK_RAM0];
  assign ram1_enb = w_wr_en[BANK_RAM1];
  assign ram2_enb = w_wr_en[BANK_RAM2];
  assign ram3_enb = w_wr_en[BANK_RAM3];

  assign ram0_wea = w_wr_en[BANK_RAM0];
  assign ram1_wea = w_wr_en[BANK_RAM1];
  assign ram2_wea = w_wr_en[BANK_RAM2];
  assign ram3_wea = w_wr_en[BANK_RAM3];

  assign ram0_web = w_wr_en[BANK_RAM0];
  assign ram1_web = w_wr_en[BANK_RAM1];
  assign ram2_web = w_wr_en[BANK_RAM2];
  assign ram3_web = w_wr_en[BANK_RAM3];

endmodule

// File: tb/tb_addr_gen_1.sv
// Directed bench for addr_gen_1 at ADDR_W=3, PIPE_LAT=3 (M=8, 4 stages).
// Inputs change 1ns after posedge, outputs sampled at negedge.
// Covers reset, continuous and bubbled issue, stage ping-pong, DONE/restart, reset in drain.
module tb_addr_gen_1;
  import addr_gen_1_pkg::*;

  localparam int AW = 3;
  localparam int PL = 3;
  localparam int M  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [AW:0]   i;
  logic [4:0]    stage;
  logic          bfu_en;
  logic ram0_ena, ram1_ena, ram2_ena, ram3_ena;
  logic ram0_enb, ram1_enb, ram2_enb, ram3_enb;
  logic ram0_wea, ram1_wea, ram2_wea, ram3_wea;
  logic ram0_web, ram1_web, ram2_web, ram3_web;
  logic          w_ram_flag;
  logic          stage_flag;
  logic [AW-1:0] w_addr_0, w_addr_1, r_addr_0, r_addr_1;
`ifdef ADDR_GEN_DONE_PULSE_EN
  logic          done;
`endif

  logic [15:0] en_vec;
  assign en_vec = {ram3_web, ram3_wea, ram3_enb, ram3_ena,
                   ram2_web, ram2_wea, ram2_enb, ram2_ena,
                   ram1_web, ram1_wea, ram1_enb, ram1_ena,
                   ram0_web, ram0_wea, ram0_enb, ram0_ena};

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_rd = 1'b0;

  always #5 clk = ~clk;

  addr_gen_1 #(.ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
`ifdef ADDR_GEN_DONE_PULSE_EN
    .done(done),
`endif
    .i(i), .stage(stage), .bfu_en(bfu_en),
    .ram0_ena(ram0_ena), .ram1_ena(ram1_ena), .ram2_ena(ram2_ena), .ram3_ena(ram3_ena),
    .ram0_enb(ram0_enb), .ram1_enb(ram1_enb), .ram2_enb(ram2_enb), .ram3_enb(ram3_enb),
    .ram0_wea(ram0_wea), .ram1_wea(ram1_wea), .ram2_wea(ram2_wea), .ram3_wea(ram3_wea),
    .ram0_web(ram0_web), .ram1_web(ram1_web), .ram2_web(ram2_web), .ram3_web(ram3_web),
    .w_ram_flag(w_ram_flag), .stage_flag(stage_flag),
    .w_addr_0(w_addr_0), .w_addr_1(w_addr_1), .r_addr_0(r_addr_0), .r_addr_1(r_addr_1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, return at negedge for sampling
  task automatic cyc(input bit r, input bit v, input bit s);
    @(posedge clk);
    #1;
    rst_n = r;
    valid = v;
    start = s;
    @(negedge clk);
  endtask

  // Expected 16-bit enable/strobe vector; read on pair sf, write bank from sf and j
  function automatic logic [15:0] exp_en(input bit rd, input bit wr, input int wj, input bit sf);
    logic [15:0] v;
    logic [15:0] nib;
    int bank;
    v = '0;
    nib = 16'h000F;
    if (rd) v = sf ? 16'h1100 : 16'h0011;
    if (wr) begin
      bank = sf ? ((wj >= 4) ? 1 : 0) : ((wj >= 4) ? 3 : 2);
      v = v | (nib << (4 * bank));
    end
    return v;
  endfunction

  task automatic cyc_check(input string tag, input bit rd, input int exp_i,
                           input bit wr, input int wj, input int stg);
    bit sf;
    sf = stg[0];
    chk({tag, "_en"}, 32'(en_vec), 32'(exp_en(rd, wr, wj, sf)));
    chk({tag, "_i"}, 32'(i), exp_i);
    chk({tag, "_stage"}, 32'(stage), stg);
    chk({tag, "_sflag"}, 32'(stage_flag), 32'(sf));
    chk({tag, "_bfu"}, 32'(bfu_en), 32'(prev_rd));
    if (rd) begin
      chk({tag, "_ra0"}, 32'(r_addr_0), exp_i);
      chk({tag, "_ra1"}, 32'(r_addr_1), exp_i);
    end
    if (wr) begin
      chk({tag, "_wa0"}, 32'(w_addr_0), (2 * wj) % M);
      chk({tag, "_wa1"}, 32'(w_addr_1), (2 * wj + 1) % M);
      chk({tag, "_wflag"}, 32'(w_ram_flag), (wj >= 4) ? 1 : 0);
    end else begin
      chk({tag, "_wflag0"}, 32'(w_ram_flag), 0);
    end
    prev_rd = rd;
  endtask

  // valid held high: 8 issues, then 3 drain cycles; start pulses must be ignored
  task automatic run_cont(input int stg, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      cyc(1'b0, 1'b1, (c == 4) || (c == 9));
      cyc_check($sformatf("s%0d_c%0d", stg, c), c < 8, (c < 8) ? c : 8,
                (c >= 3) && (c <= 10), c - 3, stg);
      if (stg == 0 && c == 8) begin
        chk("i5_wa0", 32'(w_addr_0), 2);
        chk("i5_wa1", 32'(w_addr_1), 3);
        chk("i5_wflag", 32'(w_ram_flag), 1);
        chk("i5_ram3", {28'd0, ram3_ena, ram3_enb, ram3_wea, ram3_web}, 32'hF);
      end
    end
  endtask

  // valid toggles: issues on even cycles only, bubbles preserved in the write stream
  task automatic run_toggle(input int stg);
    int n_wr;
    bit rd, wr;
    n_wr = 0;
    for (int s = 0; s < 18; s++) begin
      cyc(1'b0, (s % 2) == 0, 1'b0);
      rd = ((s % 2) == 0) && (s <= 14);
      wr = (s >= 3) && (((s - 3) % 2) == 0);
      cyc_check($sformatf("t%0d_s%0d", stg, s), rd, (s <= 15) ? (s + 1) / 2 : 8,
                wr, (s - 3) / 2, stg);
      if ((en_vec & 16'h4444) != 16'h0) n_wr++;
    end
    chk("toggle_nwr", n_wr, 8);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, 32'(en_vec), 0);
    chk({tag, "_i"}, 32'(i), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_sflag"}, 32'(stage_flag), 0);
    chk({tag, "_wflag"}, 32'(w_ram_flag), 0);
    chk({tag, "_bfu"}, 32'(bfu_en), 0);
    chk({tag, "_wa0"}, 32'(w_addr_0), 0);
    chk({tag, "_wa1"}, 32'(w_addr_1), 0);
    chk({tag, "_ra0"}, 32'(r_addr_0), 0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'(ST_IDLE));
  endtask

  initial begin
    // Reset held, then released
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_all_zero("rst");
`ifdef ADDR_GEN_DONE_PULSE_EN
    chk("rst_done", 32'(done), 0);
`endif

    // start with valid low: RUN, nothing issued, i holds
    cyc(1'b0, 1'b0, 1'b1);
    chk("idle_en", 32'(en_vec), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("run_state", 32'(dut.r_state), 32'(ST_RUN));
    chk("run_en", 32'(en_vec), 0);
    chk("run_i", 32'(i), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("hold_i", 32'(i), 0);
    chk("hold_bfu", 32'(bfu_en), 0);
    prev_rd = 1'b0;

    // Full transform: stage 0 continuous, stage 1 bubbled, stages 2-3 continuous
    run_cont(0, 11);
    run_toggle(1);
    run_cont(2, 11);
    run_cont(3, 11);

    // DONE: stage parked at NUM_STAGES, no enables
    cyc(1'b0, 1'b1, 1'b0);
    chk("done_state", 32'(dut.r_state), 32'(ST_DONE));
    chk("done_stage", 32'(stage), 4);
    chk("done_en", 32'(en_vec), 0);
    chk("done_bfu", 32'(bfu_en), 0);
    chk("done_sflag", 32'(stage_flag), 0);
`ifdef ADDR_GEN_DONE_PULSE_EN
    chk("done_pulse", 32'(done), 1);
`endif
    cyc(1'b0, 1'b1, 1'b0);
    chk("done_stage2", 32'(stage), 4);
    chk("done_en2", 32'(en_vec), 0);
`ifdef ADDR_GEN_DONE_PULSE_EN
    chk("done_pulse_end", 32'(done), 0);
`endif
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_stage_before", 32'(stage), 4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart_state", 32'(dut.r_state), 32'(ST_RUN));
    chk("restart_stage", 32'(stage), 0);
    chk("restart_i", 32'(i), 0);
    prev_rd = 1'b0;

    // Second transform aborted by reset in stage 2 DRAIN
    run_cont(0, 11);
    run_cont(1, 11);
    run_cont(2, 9);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_all_zero("abort");
    for (int k = 0; k < PL; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("abort_quiet%0d", k), 32'(en_vec), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
